// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
//
// Counting core of the stopwatch. Holds a minutes:seconds value that counts
// up or down on a one-cycle 1 Hz enable, can be preset field by field on a
// 2 Hz enable while in adjust mode, and can freeze the displayed value as a
// lap time while the live count continues underneath. Everything runs on the
// single system clock; the tick inputs are enables, not clocks.
//
// Parameters
//   MIN_MAX   largest minutes value (1..99)
//   SEC_MAX   largest seconds value (1..63)
//   MIN_W     width of the minutes field, must be able to hold MIN_MAX
//   WRAP      behaviour when counting up past MIN_MAX:SEC_MAX
//             1 = roll over to 00:00 and keep running
//             0 = hold, drop into pause and pulse expired
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   tick_1hz    one-cycle counting enable
//   tick_2hz    one-cycle adjust enable
//   pause_p     one-cycle pulse, toggles run/pause
//   lap_p       one-cycle pulse, toggles lap hold
//   sel         adjust target: 0 = minutes, 1 = seconds
//   adj         adjust mode level
//   dir         count direction: 0 = up, 1 = down
//   disp_min    minutes shown (live or lap value)
//   disp_sec    seconds shown (live or lap value)
//   running     1 while the counter advances on tick_1hz
//   lap_active  1 while the display is frozen at the lap value
//   expired     one-cycle pulse when counting stops at a limit
// ---------------------------------------------------------------------------
module stopwatch_core #(
    parameter int MIN_MAX = 59,
    parameter int SEC_MAX = 59,
    parameter int MIN_W   = 7,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             pause_p,
    input  logic             lap_p,
    input  logic             sel,
    input  logic             adj,
    input  logic             dir,
    output logic [MIN_W-1:0] disp_min,
    output logic [5:0]       disp_sec,
    output logic             running,
    output logic             lap_active,
    output logic             expired
);

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } runState_t;

    localparam logic [MIN_W-1:0] MinMax  = MIN_W'(MIN_MAX);
    localparam logic [MIN_W-1:0] MinOne  = MIN_W'(1);
    localparam logic [MIN_W-1:0] MinZero = '0;
    localparam logic [5:0]       SecMax  = 6'(SEC_MAX);
    localparam logic [5:0]       SecOne  = 6'd1;
    localparam logic [5:0]       SecZero = 6'd0;

    // Live count, lap snapshot and run state
    runState_t        state_q,      state_d;
    logic [MIN_W-1:0] min_q,        min_d;
    logic [5:0]       sec_q,        sec_d;
    logic [MIN_W-1:0] lapMin_q,     lapMin_d;
    logic [5:0]       lapSec_q,     lapSec_d;
    logic             lapActive_q,  lapActive_d;
    logic             expired_q,    expired_d;
    logic             adjPrev_q;

    // Registered copies of the outputs
    logic [MIN_W-1:0] dispMin_q,    dispMin_d;
    logic [5:0]       dispSec_q,    dispSec_d;
    logic             running_q;

    logic             adjRise;
    logic             liveAtMax;
    logic             liveAtZero;
    logic             liveAtOne;

    assign adjRise    = adj & ~adjPrev_q;
    assign liveAtMax  = (min_q == MinMax)  && (sec_q == SecMax);
    assign liveAtZero = (min_q == MinZero) && (sec_q == SecZero);
    // Counting down from 00:01 is the only step whose result is 00:00
    assign liveAtOne  = (min_q == MinZero) && (sec_q == SecOne);

    // Next-state logic for the live count, run state and lap hold.
    // Adjust mode takes precedence over counting; the run-state toggle from
    // pause_p is applied independently so it still works during adjust, and
    // an expiry in the same cycle forces PAUSE over the toggle. The counting
    // decision uses state_q, i.e. the state before any toggle this cycle.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        lapMin_d    = lapMin_q;
        lapSec_d    = lapSec_q;
        lapActive_d = lapActive_q;
        expired_d   = 1'b0;

        if (pause_p) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
        end

        if (adj) begin
            // Field-local wrap, no carry between minutes and seconds
            if (tick_2hz) begin
                if (sel) begin
                    sec_d = (sec_q == SecMax) ? SecZero : sec_q + SecOne;
                end else begin
                    min_d = (min_q == MinMax) ? MinZero : min_q + MinOne;
                end
            end
        end else if ((state_q == RUN) && tick_1hz) begin
            if (!dir) begin
                if (liveAtMax) begin
                    if (WRAP != 0) begin
                        min_d = MinZero;
                        sec_d = SecZero;
                    end else begin
                        expired_d = 1'b1;
                    end
                end else if (sec_q == SecMax) begin
                    sec_d = SecZero;
                    min_d = min_q + MinOne;
                end else begin
                    sec_d = sec_q + SecOne;
                end
            end else begin
                if (liveAtZero) begin
                    expired_d = 1'b1;
                end else begin
                    if (sec_q == SecZero) begin
                        sec_d = SecMax;
                        min_d = min_q - MinOne;
                    end else begin
                        sec_d = sec_q - SecOne;
                    end
                    if (liveAtOne) begin
                        expired_d = 1'b1;
                    end
                end
            end
        end

        if (expired_d) begin
            state_d = PAUSE;
        end

        // Entering adjust drops the lap hold so the value being edited shows.
        // The snapshot is taken from the pre-tick live value.
        if (adjRise) begin
            lapActive_d = 1'b0;
        end else if (lap_p) begin
            if (lapActive_q) begin
                lapActive_d = 1'b0;
            end else begin
                lapActive_d = 1'b1;
                lapMin_d    = min_q;
                lapSec_d    = sec_q;
            end
        end
    end

    // Display mux is evaluated on next-state values so the registered
    // display changes on the same edge as the live count.
    always_comb begin
        dispMin_d = lapActive_d ? lapMin_d : min_d;
        dispSec_d = lapActive_d ? lapSec_d : sec_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            running_q   <= 1'b1;
            min_q       <= '0;
            sec_q       <= '0;
            lapMin_q    <= '0;
            lapSec_q    <= '0;
            lapActive_q <= 1'b0;
            expired_q   <= 1'b0;
            adjPrev_q   <= 1'b0;
            dispMin_q   <= '0;
            dispSec_q   <= '0;
        end else begin
            state_q     <= state_d;
            running_q   <= (state_d == RUN);
            min_q       <= min_d;
            sec_q       <= sec_d;
            lapMin_q    <= lapMin_d;
            lapSec_q    <= lapSec_d;
            lapActive_q <= lapActive_d;
            expired_q   <= expired_d;
            adjPrev_q   <= adj;
            dispMin_q   <= dispMin_d;
            dispSec_q   <= dispSec_d;
        end
    end

    assign disp_min   = dispMin_q;
    assign disp_sec   = dispSec_q;
    assign running    = running_q;
    assign lap_active = lapActive_q;
    assign expired    = expired_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_core
//
// Drives two stopwatch_core instances with identical stimulus, one built with
// WRAP=1 and one with WRAP=0. A reference model tracks each instance as a
// single elapsed-seconds total; after every clock edge the stimulus process
// pushes the expected observable state into a per-instance queue and a
// monitor on the falling edge pops and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_stopwatch_core;

    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;
    localparam int MIN_W   = 7;
    localparam int SPAN    = SEC_MAX + 1;
    localparam int TOT_MAX = MIN_MAX * SPAN + SEC_MAX;

    typedef struct packed {
        logic [MIN_W-1:0] m;
        logic [5:0]       s;
        logic             run;
        logic             lap;
        logic             exp;
    } obs_t;

    logic clk;
    logic rst;
    logic tick1;
    logic tick2;
    logic pauseP;
    logic lapP;
    logic selL;
    logic adjL;
    logic dirL;

    logic [MIN_W-1:0] dMin [2];
    logic [5:0]       dSec [2];
    logic             dRun [2];
    logic             dLap [2];
    logic             dExp [2];

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state: whole value as total seconds
    int mTot     [2];
    int mLapTot  [2];
    bit mRun     [2];
    bit mLap     [2];
    bit mExp     [2];
    bit mAdjPrev [2];

    obs_t expQ0[$];
    obs_t expQ1[$];

    stopwatch_core #(
        .MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX), .MIN_W(MIN_W), .WRAP(1)
    ) dut0 (
        .clk(clk), .rst(rst), .tick_1hz(tick1), .tick_2hz(tick2),
        .pause_p(pauseP), .lap_p(lapP), .sel(selL), .adj(adjL), .dir(dirL),
        .disp_min(dMin[0]), .disp_sec(dSec[0]), .running(dRun[0]),
        .lap_active(dLap[0]), .expired(dExp[0])
    );

    stopwatch_core #(
        .MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX), .MIN_W(MIN_W), .WRAP(0)
    ) dut1 (
        .clk(clk), .rst(rst), .tick_1hz(tick1), .tick_2hz(tick2),
        .pause_p(pauseP), .lap_p(lapP), .sel(selL), .adj(adjL), .dir(dirL),
        .disp_min(dMin[1]), .disp_sec(dSec[1]), .running(dRun[1]),
        .lap_active(dLap[1]), .expired(dExp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t actualObs(input int k);
        obs_t a;
        a.m   = dMin[k];
        a.s   = dSec[k];
        a.run = dRun[k];
        a.lap = dLap[k];
        a.exp = dExp[k];
        return a;
    endfunction

    function automatic obs_t modelObs(input int k);
        obs_t e;
        int shown;
        shown = mLap[k] ? mLapTot[k] : mTot[k];
        e.m   = MIN_W'(shown / SPAN);
        e.s   = 6'(shown % SPAN);
        e.run = mRun[k];
        e.lap = mLap[k];
        e.exp = mExp[k];
        return e;
    endfunction

    task automatic compareObs(input string name, input int k, input obs_t a, input obs_t e);
        checkCount++;
        if (a !== e) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d: got %0d:%0d run=%0b lap=%0b exp=%0b, expected %0d:%0d run=%0b lap=%0b exp=%0b",
                     name, k, a.m, a.s, a.run, a.lap, a.exp, e.m, e.s, e.run, e.lap, e.exp);
        end
    endtask

    task automatic modelReset(input int k);
        mTot[k]     = 0;
        mLapTot[k]  = 0;
        mRun[k]     = 1'b1;
        mLap[k]     = 1'b0;
        mExp[k]     = 1'b0;
        mAdjPrev[k] = 1'b0;
    endtask

    // One clock of behaviour for instance k, from the inputs held at the edge
    task automatic modelStep(input int k, input bit wrap);
        int oldTot;
        int mm;
        int ss;
        bit ex;
        oldTot = mTot[k];
        ex     = 1'b0;
        if (adjL) begin
            if (tick2) begin
                mm = mTot[k] / SPAN;
                ss = mTot[k] % SPAN;
                if (selL) ss = (ss == SEC_MAX) ? 0 : ss + 1;
                else      mm = (mm == MIN_MAX) ? 0 : mm + 1;
                mTot[k] = mm * SPAN + ss;
            end
        end else if (mRun[k] && tick1) begin
            if (!dirL) begin
                if (mTot[k] == TOT_MAX) begin
                    if (wrap) mTot[k] = 0;
                    else      ex = 1'b1;
                end else begin
                    mTot[k] = mTot[k] + 1;
                end
            end else begin
                if (mTot[k] == 0) begin
                    ex = 1'b1;
                end else begin
                    mTot[k] = mTot[k] - 1;
                    if (mTot[k] == 0) ex = 1'b1;
                end
            end
        end
        mRun[k] = ex ? 1'b0 : (mRun[k] ^ pauseP);
        if (adjL && !mAdjPrev[k]) begin
            mLap[k] = 1'b0;
        end else if (lapP) begin
            if (mLap[k]) begin
                mLap[k] = 1'b0;
            end else begin
                mLap[k]    = 1'b1;
                mLapTot[k] = oldTot;
            end
        end
        mAdjPrev[k] = adjL;
        mExp[k]     = ex;
    endtask

    // Drive one cycle of inputs, advance the model at the edge and queue
    // the expected outputs; pulses are dropped again just after the edge.
    task automatic applyStimulus(input logic t1, input logic t2, input logic pp,
                                 input logic lp, input logic s, input logic a,
                                 input logic d);
        tick1  = t1;
        tick2  = t2;
        pauseP = pp;
        lapP   = lp;
        selL   = s;
        adjL   = a;
        dirL   = d;
        @(posedge clk);
        modelStep(0, 1'b1);
        modelStep(1, 1'b0);
        expQ0.push_back(modelObs(0));
        expQ1.push_back(modelObs(1));
        #1;
        tick1  = 1'b0;
        tick2  = 1'b0;
        pauseP = 1'b0;
        lapP   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int k, input int m, input int s,
                               input bit run, input bit lapA, input bit ex);
        obs_t e;
        e.m   = MIN_W'(m);
        e.s   = 6'(s);
        e.run = run;
        e.lap = lapA;
        e.exp = ex;
        compareObs(name, k, actualObs(k), e);
    endtask

    // Asynchronous reset asserted mid-cycle with every pulse input active;
    // outputs must clear before any clock edge and the pulses must be ignored.
    task automatic resetDut();
        @(negedge clk);
        #1;
        rst    = 1'b1;
        tick1  = 1'b1;
        tick2  = 1'b1;
        pauseP = 1'b1;
        lapP   = 1'b1;
        #1;
        checkOutput("asyncReset", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("asyncReset", 1, 0, 0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        modelReset(0);
        modelReset(1);
        expQ0.push_back(modelObs(0));
        expQ1.push_back(modelObs(1));
        #1;
        rst    = 1'b0;
        tick1  = 1'b0;
        tick2  = 1'b0;
        pauseP = 1'b0;
        lapP   = 1'b0;
        selL   = 1'b0;
        adjL   = 1'b0;
        dirL   = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (expQ0.size() > 0) compareObs("cycle", 0, actualObs(0), expQ0.pop_front());
        if (expQ1.size() > 0) compareObs("cycle", 1, actualObs(1), expQ1.pop_front());
    end

    initial begin
        logic aR;
        logic sR;
        logic dR;
        rst    = 1'b1;
        tick1  = 1'b0;
        tick2  = 1'b0;
        pauseP = 1'b0;
        lapP   = 1'b0;
        selL   = 1'b0;
        adjL   = 1'b0;
        dirL   = 1'b0;
        modelReset(0);
        modelReset(1);

        $display("[TB] reset and 61 up-count ticks");
        resetDut();
        for (int i = 0; i < 61; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("up61", 0, 1, 1, 1'b1, 1'b0, 1'b0);
        checkOutput("up61", 1, 1, 1, 1'b1, 1'b0, 1'b0);

        $display("[TB] preload 59:59 and count up past the top");
        resetDut();
        for (int i = 0; i < 59; i++) applyStimulus(0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) applyStimulus(0, 1, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("preload", 0, 59, 59, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("wrapTop", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("saturateTop", 1, 59, 59, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("saturateHold", 1, 59, 59, 1'b0, 1'b0, 1'b0);

        $display("[TB] count down to expiry");
        resetDut();
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("down1", 0, 0, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("downZero", 0, 0, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("downZero", 1, 0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("downHold", 0, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] lap hold");
        resetDut();
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("lapHeld", 0, 0, 10, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("lapRelease", 0, 0, 15, 1'b1, 1'b0, 1'b0);

        $display("[TB] seconds adjust with counting ticks present");
        resetDut();
        for (int i = 0; i < 58; i++) applyStimulus(0, 1, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        checkOutput("adjSec59", 0, 0, 59, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        checkOutput("adjSecWrap", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        checkOutput("adjSec01", 1, 0, 1, 1'b1, 1'b0, 1'b0);

        $display("[TB] pause together with a tick");
        resetDut();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("pauseTick", 0, 0, 6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("pausedHold", 0, 0, 6, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("resume", 0, 0, 6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("resumedCount", 0, 0, 8, 1'b1, 1'b0, 1'b0);
        resetDut();
        checkOutput("midRunReset", 0, 0, 0, 1'b1, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        aR = 1'b0;
        sR = 1'b0;
        dR = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(599) == 0) begin
                resetDut();
                aR = 1'b0;
                sR = 1'b0;
                dR = 1'b0;
            end
            if ($urandom_range(39) == 0) aR = ~aR;
            if ($urandom_range(7) == 0)  sR = ~sR;
            if ($urandom_range(29) == 0) dR = ~dR;
            applyStimulus($urandom_range(2) == 0, $urandom_range(2) == 0,
                          $urandom_range(15) == 0, $urandom_range(11) == 0,
                          sR, aR, dR);
        end

        @(negedge clk);
        #1;
        checkCount++;
        if ((expQ0.size() != 0) || (expQ1.size() != 0)) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", expQ0.size(), expQ1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
